// File: rtl/mips_core_pkg.sv
// Shared core types for the branch history table arbiter.
// BranchOutcome is the core-wide branch outcome type; BhtState sequences
// the table between its reset sweep and normal service.
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } BhtState;

    // Weakly-not-taken: every entry starts here after the sweep.
    localparam logic [1:0] BHT_CTR_INIT = 2'b01;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] bht_ctr_next(input logic [1:0] ctr,
                                                input BranchOutcome outcome);
        if (outcome == TAKEN) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// In-order feedback queue for the branch history table.
// With BHT_FWD_EN defined it also exposes its storage, per-slot valid bits
// and head pointer so the arbiter can forward pending outcomes.
module bht_update_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
`ifdef BHT_FWD_EN
    ,
    output logic [DEPTH-1:0][WIDTH-1:0]  o_entries,
    output logic [DEPTH-1:0]             o_valid,
    output logic [$clog2(DEPTH)-1:0]     o_head
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage has no reset; the pointers and count alone define which slots hold data.
    always_ff @(posedge clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_data;
    end

`ifdef BHT_FWD_EN
    logic [DEPTH-1:0] valid_q;

    // Slot valid bits; a push into the slot being popped (full queue) keeps it valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (i_pop)  valid_q[rd_ptr_q] <= 1'b0;
            if (i_push) valid_q[wr_ptr_q] <= 1'b1;
        end
    end

    // Flatten storage for the forwarding scan.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_entries[i] = mem_q[i];
        end
    end

    assign o_valid = valid_q;
    assign o_head  = rd_ptr_q;
`endif

endmodule

// File: rtl/branch_history_table_arbiter.sv
// Branch history table with one access per cycle shared between decode
// lookups and queued execute feedback. A reset sweep writes every counter
// to weakly-not-taken before lookups are served.
// Optional feature: define BHT_FWD_EN to forward pending queue outcomes
// to lookups of a matching index.
module branch_history_table_arbiter
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS     = 6,
    parameter int UPDATE_Q_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_req_valid,
    input  logic [ADDR_WIDTH-1:0]         i_req_pc,
    output BranchOutcome                  o_req_prediction,
    output logic                          o_req_stall,
    input  logic                          i_fb_valid,
    input  logic [ADDR_WIDTH-1:0]         i_fb_pc,
    input  BranchOutcome                  i_fb_outcome,
    output logic                          o_fb_drop,
    output logic                          o_init_done,
    output logic [$clog2(UPDATE_Q_DEPTH):0] o_q_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int Q_W     = INDEX_BITS + 1;

    BhtState               state_q;
    logic [INDEX_BITS-1:0] sweep_q;
    logic [1:0]            table_q [ENTRIES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] fb_idx;
    logic [INDEX_BITS-1:0] head_idx;
    logic [INDEX_BITS-1:0] access_idx;
    BranchOutcome          head_outcome;
    logic [Q_W-1:0]        q_head;
    logic                  q_full;
    logic                  q_empty;
    logic                  push;
    logic                  drain;
    logic [1:0]            rd_ctr;

    assign req_idx      = i_req_pc[INDEX_BITS+1:2];
    assign fb_idx       = i_fb_pc[INDEX_BITS+1:2];
    assign head_idx     = q_head[Q_W-1:1];
    assign head_outcome = BranchOutcome'(q_head[0]);
    assign o_init_done  = (state_q == RUN);

    wire unused_pc_bits = &{1'b0, i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                            i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};

`ifdef BHT_FWD_EN
    logic [UPDATE_Q_DEPTH-1:0][Q_W-1:0]   q_entries;
    logic [UPDATE_Q_DEPTH-1:0]            q_valid;
    logic [$clog2(UPDATE_Q_DEPTH)-1:0]    q_head_ptr;
`endif

    bht_update_fifo #(
        .WIDTH (Q_W),
        .DEPTH (UPDATE_Q_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (push),
        .i_data    ({fb_idx, i_fb_outcome}),
        .i_pop     (drain),
        .o_data    (q_head),
        .o_full    (q_full),
        .o_empty   (q_empty),
        .o_count   (o_q_count)
`ifdef BHT_FWD_EN
        ,
        .o_entries (q_entries),
        .o_valid   (q_valid),
        .o_head    (q_head_ptr)
`endif
    );

    // Arbitrate the single table port: a full queue beats decode, decode beats an idle drain.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        push        = 1'b0;
        drain       = 1'b0;
        o_req_stall = 1'b0;
        o_fb_drop   = 1'b0;
        if (state_q == INIT) begin
            o_req_stall = i_req_valid;
            o_fb_drop   = i_fb_valid;
        end else begin
            push = i_fb_valid;
            if (q_full) begin
                drain       = 1'b1;
                o_req_stall = i_req_valid;
            end else if (!i_req_valid && !q_empty) begin
                drain = 1'b1;
            end
        end
    end

    // Single read address: sweep slot, drain target, or lookup index.
    always_comb begin
        if (state_q == INIT) access_idx = sweep_q;
        else if (drain)      access_idx = head_idx;
        else                 access_idx = req_idx;
    end

    assign rd_ctr = table_q[access_idx];

    // Prediction from the counter MSB, optionally overridden by the youngest pending match.
    always_comb begin
        o_req_prediction = NOT_TAKEN;
        if (state_q == RUN && !drain) begin
            o_req_prediction = BranchOutcome'(rd_ctr[1]);
`ifdef BHT_FWD_EN
            for (int k = 0; k < UPDATE_Q_DEPTH; k++) begin
                if (q_valid[q_head_ptr + k[$clog2(UPDATE_Q_DEPTH)-1:0]] &&
                    q_entries[q_head_ptr + k[$clog2(UPDATE_Q_DEPTH)-1:0]][Q_W-1:1] == req_idx) begin
                    o_req_prediction =
                        BranchOutcome'(q_entries[q_head_ptr + k[$clog2(UPDATE_Q_DEPTH)-1:0]][0]);
                end
            end
`endif
        end
    end

    // Table write port: sweep initialisation or drained read-modify-write.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            table_q[sweep_q] <= BHT_CTR_INIT;
        end else if (drain) begin
            table_q[head_idx] <= bht_ctr_next(rd_ctr, head_outcome);
        end
    end

    // Sweep sequencer: walk every entry once, then serve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else if (state_q == INIT) begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == '1) state_q <= RUN;
        end
    end

endmodule
